// File: rtl/ahb_apb_pkg.sv
// Shared types, address map and burst helpers for the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam int NUM_SEL_MAP = 3;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;

    // Two-cycle ERROR response sequencer
    typedef enum logic [1:0] {
        ES_OK   = 2'd0,
        ES_ERR1 = 2'd1,
        ES_ERR2 = 2'd2
    } err_state_t;

    // APB slave windows (64 MB each)
    localparam logic [31:0] SEL0_BASE = 32'h8000_0000;
    localparam logic [31:0] SEL0_LAST = 32'h83FF_FFFF;
    localparam logic [31:0] SEL1_BASE = 32'h8400_0000;
    localparam logic [31:0] SEL1_LAST = 32'h87FF_FFFF;
    localparam logic [31:0] SEL2_BASE = 32'h8800_0000;
    localparam logic [31:0] SEL2_LAST = 32'h8BFF_FFFF;

    // Beats in a burst; 0 means undefined-length INCR
    function automatic logic [4:0] burst_len(hburst_t b);
        case (b)
            HB_SINGLE:           burst_len = 5'd1;
            HB_INCR:             burst_len = 5'd0;
            HB_WRAP4, HB_INCR4:  burst_len = 5'd4;
            HB_WRAP8, HB_INCR8:  burst_len = 5'd8;
            default:             burst_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Follows burst beat count and expected addresses; flags protocol violations.
module ahb_burst_tracker
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              Hreset,
    input  logic              en,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic [2:0]        Hburst,
    input  logic [ADDR_W-1:0] Haddr,
    output logic              burst_err
);

    logic [4:0]        beats_left;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [4:0]        len;
    logic              is_wrap;

    // Address the following beat must carry, given this beat's size and burst type
    always_comb begin
        len       = burst_len(hburst_t'(Hburst));
        step      = ADDR_W'(1) << Hsize;
        wrap_mask = (step * ADDR_W'(len)) - ADDR_W'(1);
        is_wrap   = (Hburst == HB_WRAP4) || (Hburst == HB_WRAP8) || (Hburst == HB_WRAP16);
        if (is_wrap)
            next_addr = (Haddr & ~wrap_mask) | ((Haddr + step) & wrap_mask);
        else
            next_addr = Haddr + step;
    end

    // Beat bookkeeping; BUSY and stalled cycles leave everything unchanged
    always_ff @(posedge clock) begin
        if (Hreset) begin
            beats_left <= 5'd0;
            exp_addr   <= '0;
            burst_err  <= 1'b0;
        end else if (en && Hreadyin) begin
            case (htrans_t'(Htrans))
                HT_NONSEQ: begin
                    if (beats_left != 5'd0)
                        burst_err <= 1'b1;
                    beats_left <= (len == 5'd0) ? 5'd0 : len - 5'd1;
                    exp_addr   <= next_addr;
                end
                HT_SEQ: begin
                    if ((beats_left == 5'd0) && (Hburst != HB_INCR))
                        burst_err <= 1'b1;
                    if (Haddr != exp_addr)
                        burst_err <= 1'b1;
                    if (beats_left != 5'd0)
                        beats_left <= beats_left - 5'd1;
                    exp_addr <= next_addr;
                end
                HT_IDLE: begin
                    if (beats_left != 5'd0) begin
                        burst_err  <= 1'b1;
                        beats_left <= 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB responder front-end of the AHB-to-APB bridge: decode, pipelining, error response.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 3
) (
    input  logic               clock,
    input  logic               Hreset,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [2:0]         Hsize,
    input  logic [2:0]         Hburst,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               bridge_ready,
    output logic [DATA_W-1:0]  Hrdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic               valid,
    output logic [NUM_SEL-1:0] tempselx,
    output logic [ADDR_W-1:0]  Haddr1,
    output logic [ADDR_W-1:0]  Haddr2,
    output logic [DATA_W-1:0]  Hwdata1,
    output logic [DATA_W-1:0]  Hwdata2,
    output logic               Hwritereg,
    output logic               Hwritereg1,
    output logic               burst_err,
    output logic [1:0]         err_state
);

    // Handshake: an address phase is taken when Hreadyin is high and Htrans is
    // NONSEQ or SEQ; valid tells the APB side that this phase is a good transfer.

    err_state_t state, state_nxt;
    logic [2:0] sel_dec;
    logic       accept;
    logic       misalign;
    logic       bad;

    // Address decode and transfer qualification
    always_comb begin
        sel_dec[0] = (Haddr >= ADDR_W'(SEL0_BASE)) && (Haddr <= ADDR_W'(SEL0_LAST));
        sel_dec[1] = (Haddr >= ADDR_W'(SEL1_BASE)) && (Haddr <= ADDR_W'(SEL1_LAST));
        sel_dec[2] = (Haddr >= ADDR_W'(SEL2_BASE)) && (Haddr <= ADDR_W'(SEL2_LAST));
        accept     = Hreadyin && ((Htrans == HT_NONSEQ) || (Htrans == HT_SEQ));
        misalign   = ((Hsize == 3'd1) && Haddr[0]) || ((Hsize == 3'd2) && (Haddr[1:0] != 2'b00));
        bad        = (sel_dec == 3'b000) || (Hsize > 3'd2) || misalign;
    end

    assign tempselx  = NUM_SEL'(sel_dec);
    assign valid     = !Hreset && accept && !bad && (state != ES_ERR1);
    assign Hrdata    = Prdata;
    assign err_state = state;

    // Error FSM state register
    always_ff @(posedge clock) begin
        if (Hreset)
            state <= ES_OK;
        else
            state <= state_nxt;
    end

    // Error FSM next state: ERR1 always advances, ERR2 can restart on a new bad transfer
    always_comb begin
        state_nxt = state;
        case (state)
            ES_OK:   if (accept && bad) state_nxt = ES_ERR1;
            ES_ERR1: state_nxt = ES_ERR2;
            ES_ERR2: state_nxt = (accept && bad) ? ES_ERR1 : ES_OK;
            default: state_nxt = ES_OK;
        endcase
    end

    // Error FSM outputs: wait state then ready, both cycles signalling ERROR
    always_comb begin
        Hreadyout = bridge_ready;
        Hresp     = HR_OKAY;
        case (state)
            ES_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = HR_ERROR;
            end
            ES_ERR2: begin
                Hreadyout = 1'b1;
                Hresp     = HR_ERROR;
            end
            default: ;
        endcase
    end

    // Address/data/direction pipeline, advancing only when the bus is ready
    always_ff @(posedge clock) begin
        if (Hreset) begin
            Haddr1     <= '0;
            Haddr2     <= '0;
            Hwdata1    <= '0;
            Hwdata2    <= '0;
            Hwritereg  <= 1'b0;
            Hwritereg1 <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1     <= Haddr;
            Haddr2     <= Haddr1;
            Hwdata1    <= Hwdata;
            Hwdata2    <= Hwdata1;
            Hwritereg  <= Hwrite;
            Hwritereg1 <= Hwritereg;
        end
    end

    // Burst checking is suspended while the first ERROR cycle ignores the bus
    ahb_burst_tracker #(.ADDR_W(ADDR_W)) u_burst (
        .clock     (clock),
        .Hreset    (Hreset),
        .en        (state != ES_ERR1),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hsize     (Hsize),
        .Hburst    (Hburst),
        .Haddr     (Haddr),
        .burst_err (burst_err)
    );

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for the AHB slave front-end.
module tb_ahb_slave_if;
    import ahb_apb_pkg::*;

    logic        clock;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        bridge_ready;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1, Haddr2;
    logic [31:0] Hwdata1, Hwdata2;
    logic        Hwritereg, Hwritereg1;
    logic        burst_err;
    logic [1:0]  err_state;

    int total = 0;
    int bad   = 0;

    ahb_slave_if dut (
        .clock        (clock),
        .Hreset       (Hreset),
        .Hwrite       (Hwrite),
        .Hreadyin     (Hreadyin),
        .Htrans       (Htrans),
        .Hsize        (Hsize),
        .Hburst       (Hburst),
        .Haddr        (Haddr),
        .Hwdata       (Hwdata),
        .Prdata       (Prdata),
        .bridge_ready (bridge_ready),
        .Hrdata       (Hrdata),
        .Hreadyout    (Hreadyout),
        .Hresp        (Hresp),
        .valid        (valid),
        .tempselx     (tempselx),
        .Haddr1       (Haddr1),
        .Haddr2       (Haddr2),
        .Hwdata1      (Hwdata1),
        .Hwdata2      (Hwdata2),
        .Hwritereg    (Hwritereg),
        .Hwritereg1   (Hwritereg1),
        .burst_err    (burst_err),
        .err_state    (err_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive one address phase
    task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [2:0] bu);
        Htrans = tr;
        Hwrite = wr;
        Haddr  = a;
        Hsize  = sz;
        Hburst = bu;
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        drive(HT_NONSEQ, 1'b1, 32'h8000_0000, 3'd2, HB_SINGLE);
        repeat (2) cyc();
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL reset_hreadyout got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL reset_hresp got=%b exp=00", Hresp); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (Haddr1 !== 32'h0) begin bad++; $display("FAIL reset_haddr1 got=%h exp=0", Haddr1); end
        total++; if (burst_err !== 1'b0) begin bad++; $display("FAIL reset_burst_err got=%b exp=0", burst_err); end
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        Hreset = 1'b0;
    endtask

    task automatic test_single_write();
        cyc();
        drive(HT_NONSEQ, 1'b1, 32'h8000_0010, 3'd2, HB_SINGLE);
        Hwdata = 32'h0;
        #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", valid); end
        total++; if (tempselx !== 3'b001) begin bad++; $display("FAIL single_sel got=%b exp=001", tempselx); end
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        Hwdata = 32'hDEAD_BEEF;
        #1;
        total++; if (Haddr1 !== 32'h8000_0010) begin bad++; $display("FAIL single_haddr1 got=%h exp=80000010", Haddr1); end
        total++; if (Hwritereg !== 1'b1) begin bad++; $display("FAIL single_hwritereg got=%b exp=1", Hwritereg); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", valid); end
        cyc();
        total++; if (Hwdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_hwdata1 got=%h exp=deadbeef", Hwdata1); end
        total++; if (Haddr2 !== 32'h8000_0010) begin bad++; $display("FAIL single_haddr2 got=%h exp=80000010", Haddr2); end
        total++; if (Hwritereg1 !== 1'b1) begin bad++; $display("FAIL single_hwritereg1 got=%b exp=1", Hwritereg1); end
        cyc();
        total++; if (Hwdata2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_hwdata2 got=%h exp=deadbeef", Hwdata2); end
        Prdata = 32'h1234_5678;
        #1;
        total++; if (Hrdata !== 32'h1234_5678) begin bad++; $display("FAIL hrdata got=%h exp=12345678", Hrdata); end
    endtask

    task automatic test_hold();
        cyc();
        Hreadyin = 1'b0;
        drive(HT_NONSEQ, 1'b1, 32'h8000_0020, 3'd2, HB_SINGLE);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", valid); end
        cyc();
        total++; if (Haddr1 !== 32'h0) begin bad++; $display("FAIL hold_haddr1 got=%h exp=0", Haddr1); end
        total++; if (Hwritereg !== 1'b0) begin bad++; $display("FAIL hold_hwritereg got=%b exp=0", Hwritereg); end
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        Hreadyin = 1'b1;
    endtask

    task automatic test_error();
        cyc();
        drive(HT_NONSEQ, 1'b0, 32'h9000_0000, 3'd2, HB_SINGLE);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL err_valid got=%b exp=0", valid); end
        total++; if (tempselx !== 3'b000) begin bad++; $display("FAIL err_sel got=%b exp=000", tempselx); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL err_pre_ready got=%b exp=1", Hreadyout); end
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL err1_ready got=%b exp=0", Hreadyout); end
        total++; if (Hresp !== 2'b01) begin bad++; $display("FAIL err1_hresp got=%b exp=01", Hresp); end
        total++; if (err_state !== ES_ERR1) begin bad++; $display("FAIL err1_state got=%0d exp=%0d", err_state, ES_ERR1); end
        cyc();
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL err2_ready got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b01) begin bad++; $display("FAIL err2_hresp got=%b exp=01", Hresp); end
        cyc();
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL err_done_hresp got=%b exp=00", Hresp); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL err_done_ready got=%b exp=1", Hreadyout); end
        // misaligned word, then a good transfer during the second ERROR cycle
        drive(HT_NONSEQ, 1'b0, 32'h8000_0002, 3'd2, HB_SINGLE);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL misalign_valid got=%b exp=0", valid); end
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (Hresp !== 2'b01 || Hreadyout !== 1'b0) begin bad++; $display("FAIL misalign_err1 got=%b/%b exp=01/0", Hresp, Hreadyout); end
        cyc();
        drive(HT_NONSEQ, 1'b0, 32'h8000_0004, 3'd2, HB_SINGLE);
        #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL err2_good_valid got=%b exp=1", valid); end
        total++; if (Hresp !== 2'b01) begin bad++; $display("FAIL err2_good_hresp got=%b exp=01", Hresp); end
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL err2_exit_hresp got=%b exp=00", Hresp); end
        // oversized transfer
        drive(HT_NONSEQ, 1'b0, 32'h8000_0008, 3'd3, HB_SINGLE);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL size3_valid got=%b exp=0", valid); end
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (Hresp !== 2'b01) begin bad++; $display("FAIL size3_hresp got=%b exp=01", Hresp); end
        repeat (2) cyc();
    endtask

    task automatic test_bursts();
        logic [31:0] wrap_a [4];
        logic [31:0] incr_a [6];
        wrap_a[0] = 32'h8800_0008; wrap_a[1] = 32'h8800_000C;
        wrap_a[2] = 32'h8800_0000; wrap_a[3] = 32'h8800_0004;
        for (int i = 0; i < 6; i++) incr_a[i] = 32'h8000_0100 + 32'(2 * i);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? HT_NONSEQ : HT_SEQ, 1'b1, 32'h8400_0000 + 32'(4 * i), 3'd2, HB_INCR4);
            #1;
            total++; if (valid !== 1'b1 || tempselx !== 3'b010) begin bad++; $display("FAIL incr4_beat%0d got=%b/%b exp=1/010", i, valid, tempselx); end
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? HT_NONSEQ : HT_SEQ, 1'b0, wrap_a[i], 3'd2, HB_WRAP4);
            #1;
            total++; if (valid !== 1'b1 || tempselx !== 3'b100) begin bad++; $display("FAIL wrap4_beat%0d got=%b/%b exp=1/100", i, valid, tempselx); end
            cyc();
        end
        for (int i = 0; i < 6; i++) begin
            drive((i == 0) ? HT_NONSEQ : HT_SEQ, 1'b1, incr_a[i], 3'd1, HB_INCR);
            #1;
            cyc();
        end
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        cyc();
        total++; if (burst_err !== 1'b0) begin bad++; $display("FAIL bursts_clean got=%b exp=0", burst_err); end
    endtask

    task automatic test_burst_violation();
        cyc();
        drive(HT_NONSEQ, 1'b1, 32'h8000_0000, 3'd2, HB_INCR4); cyc();
        drive(HT_SEQ,    1'b1, 32'h8000_0004, 3'd2, HB_INCR4); cyc();
        drive(HT_SEQ,    1'b1, 32'h8000_0008, 3'd2, HB_INCR4); cyc();
        total++; if (burst_err !== 1'b0) begin bad++; $display("FAIL viol_pre got=%b exp=0", burst_err); end
        drive(HT_NONSEQ, 1'b1, 32'h8000_0040, 3'd2, HB_SINGLE); cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (burst_err !== 1'b1) begin bad++; $display("FAIL viol_set got=%b exp=1", burst_err); end
        repeat (3) cyc();
        total++; if (burst_err !== 1'b1) begin bad++; $display("FAIL viol_sticky got=%b exp=1", burst_err); end
    endtask

    task automatic test_reset_in_err1();
        cyc();
        drive(HT_NONSEQ, 1'b0, 32'h9000_0000, 3'd2, HB_SINGLE);
        cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL rst_err1_entry got=%b exp=0", Hreadyout); end
        Hreset = 1'b1;
        cyc();
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_err1_ready got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL rst_err1_hresp got=%b exp=00", Hresp); end
        total++; if (burst_err !== 1'b0) begin bad++; $display("FAIL rst_burst_err got=%b exp=0", burst_err); end
        bridge_ready = 1'b0;
        #1;
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL bridge_not_ready got=%b exp=0", Hreadyout); end
        bridge_ready = 1'b1;
        Hreset = 1'b0;
    endtask

    task automatic test_addr_mismatch();
        cyc();
        drive(HT_NONSEQ, 1'b0, 32'h8000_0000, 3'd2, HB_INCR4); cyc();
        drive(HT_SEQ,    1'b0, 32'h8000_0008, 3'd2, HB_INCR4); cyc();
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        #1;
        total++; if (burst_err !== 1'b1) begin bad++; $display("FAIL mismatch_err got=%b exp=1", burst_err); end
        cyc();
    endtask

    initial begin
        Hreset       = 1'b1;
        Hreadyin     = 1'b1;
        bridge_ready = 1'b1;
        Hwdata       = 32'h0;
        Prdata       = 32'h0;
        drive(HT_IDLE, 1'b0, 32'h0, 3'd0, HB_SINGLE);
        test_reset();
        test_single_write();
        test_hold();
        test_error();
        test_bursts();
        test_burst_violation();
        test_reset_in_err1();
        test_addr_mismatch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
